// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence-detector family:
// state encodings and the default 4-bit test pattern.
package seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        GAP    = ST_GAP,
        PARITY = ST_PARITY,
        DONE   = ST_DONE
    } seq_state_t;

    localparam logic [3:0] SEQ_PAT_1001 = 4'b1001;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-first shift register. Zeros shift in at the LSB, so after W shifts
// the register is empty and the serial output rests at 0.
module seq_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] din_par,
    output logic         ser_out
);

    logic [W-1:0] sr_reg;
    logic [W-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = 1'b0;
            end else begin : g_up
                assign shifted[gi] = sr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= din_par;
        end else if (shift_en) begin
            sr_reg <= shifted;
        end
    end

    assign ser_out = sr_reg[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first rep_count times with
// idle gaps between frames. Define SEQ_TX_PARITY_EN to append an even-parity bit per frame.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             busy,
    output logic             frame_start,
    output logic             done
);

`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_W = PAT_W + 1;
`else
    localparam int FRAME_W = PAT_W;
`endif
    localparam int               BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    seq_state_t       state_reg,   state_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0] rem_reg,     rem_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [PAT_W-1:0] pat_sh_reg;
    logic [GAP_W-1:0] gap_sh_reg;

    logic             sr_load;
    logic             sr_shift;
    logic             frame_end;
    logic [PAT_W-1:0] load_pat;

    // The whole frame (data plus optional parity) goes through the shift register.
    function automatic logic [FRAME_W-1:0] frame_word(input logic [PAT_W-1:0] p);
`ifdef SEQ_TX_PARITY_EN
        return {p, ^p};
`else
        return p;
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            rem_reg     <= '0;
            gap_cnt_reg <= '0;
            pat_sh_reg  <= '0;
            gap_sh_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            rem_reg     <= rem_next;
            gap_cnt_reg <= gap_cnt_next;
            if (state_reg == IDLE && start) begin
                pat_sh_reg <= pattern;
                gap_sh_reg <= gap;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        rem_next     = rem_reg;
        gap_cnt_next = gap_cnt_reg;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        frame_end    = 1'b0;
        load_pat     = pat_sh_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    load_pat = pattern;
                    rem_next = rep_count;
                    if (rep_count != '0) begin
                        state_next   = SHIFT;
                        bit_cnt_next = '0;
                        sr_load      = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt_reg == LAST_BIT) begin
`ifdef SEQ_TX_PARITY_EN
                    state_next = PARITY;
                    sr_shift   = 1'b1;
`else
                    frame_end  = 1'b1;
`endif
                end else begin
                    bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    sr_shift     = 1'b1;
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PARITY: frame_end = 1'b1;
`endif
            GAP: begin
                if (gap_cnt_reg == gap_sh_reg - GAP_W'(1)) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    sr_load      = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Shifting once more after the last bit drains the register so dout idles at 0.
        if (frame_end) begin
            rem_next = rem_reg - CNT_W'(1);
            if (rem_reg == CNT_W'(1)) begin
                state_next = DONE;
                sr_shift   = 1'b1;
            end else if (gap_sh_reg != '0) begin
                state_next   = GAP;
                gap_cnt_next = '0;
                sr_shift     = 1'b1;
            end else begin
                state_next   = SHIFT;
                bit_cnt_next = '0;
                sr_load      = 1'b1;
            end
        end
    end

    seq_shift_reg #(
        .W (FRAME_W)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (sr_load),
        .shift_en (sr_shift),
        .din_par  (frame_word(load_pat)),
        .ser_out  (dout)
    );

    assign busy        = (state_reg != IDLE);
    assign frame_start = (state_reg == SHIFT) && (bit_cnt_reg == '0);
    assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx; expectations follow SEQ_TX_PARITY_EN.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int FL = PAT_W + 1;
`else
    localparam int FL = PAT_W;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] rep_count = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             dout, busy, frame_start, done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] cap_dout, cap_busy, cap_fs, cap_done;

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern     (pattern),
        .rep_count   (rep_count),
        .gap         (gap),
        .dout        (dout),
        .busy        (busy),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Start a run and record n cycles of outputs (MSB of the capture = cycle 1).
    // Optionally re-assert start with other inputs at cycle rk for three cycles.
    task automatic run(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g,
                       input int n, input int rk, input logic [3:0] rp,
                       input logic [7:0] rr, input logic [3:0] rg);
        @(negedge clk);
        pattern = p; rep_count = r; gap = g; start = 1'b1;
        cap_dout = '0; cap_busy = '0; cap_fs = '0; cap_done = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cap_dout = {cap_dout[62:0], dout};
            cap_busy = {cap_busy[62:0], busy};
            cap_fs   = {cap_fs[62:0], frame_start};
            cap_done = {cap_done[62:0], done};
            if (k == 1) start = 1'b0;
            if (k == rk) begin
                start = 1'b1; pattern = rp; rep_count = rr; gap = rg;
            end
            if (rk != 0 && k == rk + 3) start = 1'b0;
        end
        $display("[TB] run pat=%b rep=%0d gap=%0d cycles=%0d dout=%b busy=%b done=%b",
                 p, r, g, n, cap_dout[19:0], cap_busy[19:0], cap_done[19:0]);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({dout, busy, frame_start, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000", {dout, busy, frame_start, done});
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({dout, busy, frame_start, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %b expected 0000", {dout, busy, frame_start, done});
        end
        $display("[TB] reset released, outputs=%b", {dout, busy, frame_start, done});
    endtask

    task automatic test_gap0();
        logic [63:0] e_d, e_b, e_f, e_n;
`ifdef SEQ_TX_PARITY_EN
        e_d = 17'b10010100101001000; e_b = 17'b11111111111111110;
        e_f = 17'b10000100001000000; e_n = 17'b00000000000000010;
`else
        e_d = 14'b10011001100100; e_b = 14'b11111111111110;
        e_f = 14'b10001000100000; e_n = 14'b00000000000010;
`endif
        run(SEQ_PAT_1001, 8'd3, 4'd0, 3 * FL + 2, 0, 4'd0, 8'd0, 4'd0);
        tests_run += 4;
        if (cap_dout !== e_d) begin tests_failed++; $display("FAIL gap0_dout: got %b expected %b", cap_dout[19:0], e_d[19:0]); end
        if (cap_busy !== e_b) begin tests_failed++; $display("FAIL gap0_busy: got %b expected %b", cap_busy[19:0], e_b[19:0]); end
        if (cap_fs   !== e_f) begin tests_failed++; $display("FAIL gap0_frame_start: got %b expected %b", cap_fs[19:0], e_f[19:0]); end
        if (cap_done !== e_n) begin tests_failed++; $display("FAIL gap0_done: got %b expected %b", cap_done[19:0], e_n[19:0]); end
    endtask

    task automatic test_gap();
        logic [63:0] e_d, e_f, e_n;
`ifdef SEQ_TX_PARITY_EN
        e_d = 14'b10010001001000; e_f = 14'b10000001000000; e_n = 14'b00000000000010;
`else
        e_d = 12'b100100100100; e_f = 12'b100000100000; e_n = 12'b000000000010;
`endif
        run(SEQ_PAT_1001, 8'd2, 4'd2, 2 * FL + 4, 0, 4'd0, 8'd0, 4'd0);
        tests_run += 4;
        if (cap_dout !== e_d) begin tests_failed++; $display("FAIL gap2_dout: got %b expected %b", cap_dout[19:0], e_d[19:0]); end
        if (cap_fs   !== e_f) begin tests_failed++; $display("FAIL gap2_frame_start: got %b expected %b", cap_fs[19:0], e_f[19:0]); end
        if (cap_done !== e_n) begin tests_failed++; $display("FAIL gap2_done: got %b expected %b", cap_done[19:0], e_n[19:0]); end
        if ($countones(cap_busy) != 2 * FL + 3) begin
            tests_failed++;
            $display("FAIL gap2_busy_cycles: got %0d expected %0d", $countones(cap_busy), 2 * FL + 3);
        end
    endtask

    task automatic test_rep0();
        run(4'b1111, 8'd0, 4'd3, 3, 0, 4'd0, 8'd0, 4'd0);
        tests_run += 4;
        if (cap_dout !== 64'b000) begin tests_failed++; $display("FAIL rep0_dout: got %b expected 000", cap_dout[2:0]); end
        if (cap_busy !== 64'b100) begin tests_failed++; $display("FAIL rep0_busy: got %b expected 100", cap_busy[2:0]); end
        if (cap_done !== 64'b100) begin tests_failed++; $display("FAIL rep0_done: got %b expected 100", cap_done[2:0]); end
        if (cap_fs   !== 64'b000) begin tests_failed++; $display("FAIL rep0_frame_start: got %b expected 000", cap_fs[2:0]); end
    endtask

    task automatic test_restart_ignored();
        logic [63:0] e_d, e_n;
`ifdef SEQ_TX_PARITY_EN
        e_d = 12'b100101001000; e_n = 12'b000000000010;
`else
        e_d = 10'b1001100100;   e_n = 10'b0000000010;
`endif
        run(SEQ_PAT_1001, 8'd2, 4'd0, 2 * FL + 2, 2, 4'b1111, 8'd9, 4'd3);
        tests_run += 2;
        if (cap_dout !== e_d) begin tests_failed++; $display("FAIL restart_dout: got %b expected %b", cap_dout[19:0], e_d[19:0]); end
        if (cap_done !== e_n) begin tests_failed++; $display("FAIL restart_done: got %b expected %b", cap_done[19:0], e_n[19:0]); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e_d, e_b, e_f, e_n;
`ifdef SEQ_TX_PARITY_EN
        e_d = 14'b01100001100000; e_b = 14'b11111101111110;
        e_f = 14'b10000001000000; e_n = 14'b00000100000010;
`else
        e_d = 12'b011000110000;   e_b = 12'b111110111110;
        e_f = 12'b100000100000;   e_n = 12'b000010000010;
`endif
        run(4'b0110, 8'd1, 4'd0, 2 * FL + 4, FL, 4'b1100, 8'd1, 4'd0);
        tests_run += 4;
        if (cap_dout !== e_d) begin tests_failed++; $display("FAIL b2b_dout: got %b expected %b", cap_dout[19:0], e_d[19:0]); end
        if (cap_busy !== e_b) begin tests_failed++; $display("FAIL b2b_busy: got %b expected %b", cap_busy[19:0], e_b[19:0]); end
        if (cap_fs   !== e_f) begin tests_failed++; $display("FAIL b2b_frame_start: got %b expected %b", cap_fs[19:0], e_f[19:0]); end
        if (cap_done !== e_n) begin tests_failed++; $display("FAIL b2b_done: got %b expected %b", cap_done[19:0], e_n[19:0]); end
    endtask

    task automatic test_reset_midrun();
        logic        seen_done;
        logic [63:0] e_d, e_n;
        @(negedge clk);
        pattern = 4'b1011; rep_count = 8'd3; gap = 4'd0; start = 1'b1;
        // Bit 2 of frame 2 is cycle FL+3.
        for (int k = 1; k <= FL + 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        tests_run++;
        if ({dout, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midrun_bit2: got dout,busy=%b expected 11", {dout, busy});
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({dout, busy, frame_start, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrun_async_reset: got %b expected 0000", {dout, busy, frame_start, done});
        end
        seen_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen_done = seen_done | done | busy;
        end
        reset = 1'b1;
        @(negedge clk);
        seen_done = seen_done | done | busy;
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_no_done: got %b expected 0", seen_done);
        end
        $display("[TB] reset mid-run at frame 2 bit 2, outputs after=%b", {dout, busy, frame_start, done});
`ifdef SEQ_TX_PARITY_EN
        e_d = 7'b1011100; e_n = 7'b0000010;
`else
        e_d = 6'b101100;  e_n = 6'b000010;
`endif
        run(4'b1011, 8'd1, 4'd0, FL + 2, 0, 4'd0, 8'd0, 4'd0);
        tests_run += 2;
        if (cap_dout !== e_d) begin tests_failed++; $display("FAIL after_reset_dout: got %b expected %b", cap_dout[19:0], e_d[19:0]); end
        if (cap_done !== e_n) begin tests_failed++; $display("FAIL after_reset_done: got %b expected %b", cap_done[19:0], e_n[19:0]); end
    endtask

    task automatic test_max_rep();
        int fs_cnt = 0;
        int ones = 0;
        int done_k = 0;
        @(negedge clk);
        pattern = SEQ_PAT_1001; rep_count = 8'hFF; gap = 4'd0; start = 1'b1;
        for (int k = 1; k <= 1500 && done_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (frame_start) fs_cnt++;
            if (dout) ones++;
            if (done) done_k = k;
        end
        $display("[TB] run pat=1001 rep=255 gap=0 frames=%0d ones=%0d done_cycle=%0d", fs_cnt, ones, done_k);
        tests_run += 3;
        if (fs_cnt != 255) begin tests_failed++; $display("FAIL maxrep_frames: got %0d expected 255", fs_cnt); end
        if (ones != 510) begin tests_failed++; $display("FAIL maxrep_ones: got %0d expected 510", ones); end
        if (done_k != 255 * FL + 1) begin
            tests_failed++;
            $display("FAIL maxrep_done_cycle: got %0d expected %0d (0 = timeout)", done_k, 255 * FL + 1);
        end
    endtask

    initial begin
        test_reset();
        test_gap0();
        test_gap();
        test_rep0();
        test_restart_ignored();
        test_back_to_back();
        test_reset_midrun();
        test_max_rep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
